// File: rtl/mux_channel_arbiter.sv
// mux_channel_arbiter
// Round-robin arbiter that shares one registered W-bit output channel among
// N_REQ valid/ready requesters. The winner's data is routed through a binary
// tree of 2:1 mux cells and captured in a single output stage. The output
// stage has its own valid/ready handshake, so it sustains one word per cycle.
module mux_channel_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,        // asynchronous, active low
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*W-1:0]         req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       out_valid,
   output logic [W-1:0]               out_data,
   output logic [$clog2(N_REQ)-1:0]   out_src,
   input  logic                       out_ready
);

   localparam int SW    = $clog2(N_REQ);
   localparam int N_PAD = 1 << SW;      // leaves of the mux tree

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   last_grant_q, last_grant_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [SW-1:0]   out_src_q, out_src_d;

   logic [SW-1:0]   pick_g;
   logic            pick_found;
   logic            can_load;
   logic            accept;
   logic [W-1:0]    mux_tree [1:2*N_PAD-1];

   // The only pointer arithmetic in the block: modulo-N_REQ increment.
   function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p);
      return (p == SW'(N_REQ - 1)) ? '0 : p + SW'(1);
   endfunction

   // Cyclic search for the first valid requester after the last grant.
   always_comb begin
      logic [SW-1:0] ptr;
      pick_g     = '0;
      pick_found = 1'b0;
      ptr        = wrap_inc(last_grant_q);
      for (int i = 0; i < N_REQ; i++) begin
         if (!pick_found && req_valid[ptr]) begin
            pick_g     = ptr;
            pick_found = 1'b1;
         end
         ptr = wrap_inc(ptr);
      end
   end

   // The output register can take a word when empty or when it is being drained.
   assign can_load = (state_q == EMPTY) || out_ready;
   assign accept   = can_load && pick_found;

   genvar gi;

   // One-hot ready toward the winner; independent of req_data.
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_ready
         assign req_ready[gi] = accept && (pick_g == SW'(gi));
      end
   endgenerate

   // Mux tree leaves, heap-indexed: leaf k lives at N_PAD+k. Padding leaves
   // (non power-of-two N_REQ) are tied to zero and are never selected.
   generate
      for (gi = 0; gi < N_PAD; gi++) begin : g_leaf
         if (gi < N_REQ) begin : g_real
            assign mux_tree[N_PAD+gi] = req_data[gi*W +: W];
         end else begin : g_pad
            assign mux_tree[N_PAD+gi] = '0;
         end
      end
   endgenerate

   // 2:1 mux cells: the cell at depth gi is steered by pick_g bit SW-1-gi,
   // so the root (node 1) uses the MSB and the last level uses the LSB.
   generate
      for (gi = 0; gi < SW; gi++) begin : g_lvl
         for (genvar gj = 0; gj < (1 << gi); gj++) begin : g_cell
            localparam int NODE = (1 << gi) + gj;
            assign mux_tree[NODE] = pick_g[SW-1-gi] ? mux_tree[2*NODE+1]
                                                    : mux_tree[2*NODE];
         end
      end
   endgenerate

   // Next-state and datapath load decisions.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      if (accept) begin
         state_d      = FULL;
         last_grant_d = pick_g;
         out_data_d   = mux_tree[1];
         out_src_d    = pick_g;
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
      end
   end

   // State register; reset discards any pending word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Output stage and round-robin pointer; pointer resets so requester 0 wins first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= SW'(N_REQ - 1);
         out_data_q   <= '0;
         out_src_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_channel_arbiter.sv
// Self-checking bench for mux_channel_arbiter (N_REQ=4, W=8). A small
// reference model predicts grants; accepted words go into a scoreboard
// queue and are compared while they sit in the output register.
module tb_mux_channel_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_ready = 1'b0;

   typedef struct packed {
      logic [1:0]   src;
      logic [W-1:0] data;
   } exp_t;

   exp_t   sb_q[$];
   int     n_cmp = 0;
   int     n_err = 0;

   int         m_last;
   bit         m_full;
   logic [7:0] m_hold_data;
   logic [1:0] m_hold_src;

   mux_channel_arbiter #(.N_REQ(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_last      = N - 1;
      m_full      = 1'b0;
      m_hold_data = '0;
      m_hold_src  = '0;
   endtask

   // Called at posedge+1: drive one cycle, check at the negedge, advance model.
   task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy);
      int         g;
      bit         found;
      bit         can;
      logic [N-1:0] exp_rdy;
      exp_t       e;
      req_valid = v;
      req_data  = d;
      out_ready = rdy;
      found = 1'b0;
      g     = 0;
      for (int i = 1; i <= N; i++) begin
         int k;
         k = (m_last + i) % N;
         if (!found && v[k]) begin
            found = 1'b1;
            g     = k;
         end
      end
      can     = !m_full || rdy;
      exp_rdy = (can && found) ? N'(1 << g) : '0;
      #4;
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_full && sb_q.size() > 0) begin
         e = sb_q[0];
         check_eq("out_valid", 32'(out_valid), 32'd1);
         check_eq("out_data", 32'(out_data), 32'(e.data));
         check_eq("out_src", 32'(out_src), 32'(e.src));
         if (rdy) begin
            void'(sb_q.pop_front());
            $display("xfer src=%0d data=0x%02h", e.src, e.data);
            m_full = 1'b0;
         end
      end else begin
         check_eq("out_valid", 32'(out_valid), 32'd0);
         check_eq("out_data_hold", 32'(out_data), 32'(m_hold_data));
         check_eq("out_src_hold", 32'(out_src), 32'(m_hold_src));
      end
      if (can && found) begin
         e.src  = 2'(g);
         e.data = d[g*W +: W];
         sb_q.push_back(e);
         m_full      = 1'b1;
         m_last      = g;
         m_hold_data = e.data;
         m_hold_src  = e.src;
      end
      @(posedge clk);
      #1;
   endtask

   // Assert reset between edges; outputs must clear without a clock edge.
   task automatic reset_async();
      rst = 1'b0;
      #2;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_src", 32'(out_src), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   localparam logic [N*W-1:0] RR_DATA = 32'h13121110;

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      check_eq("init_out_valid", 32'(out_valid), 32'd0);
      check_eq("init_out_data", 32'(out_data), 32'd0);
      rst = 1'b1;

      // Idle with out_ready high while empty.
      repeat (2) cycle('0, '0, 1'b1);
      repeat (2) cycle(4'b1111, RR_DATA, 1'b1);

      // Reset mid-run, then a single request from requester 2.
      reset_async();
      cycle(4'b0100, 32'h00A50000, 1'b1);

      // Reset while FULL, then round-robin with all four valid.
      reset_async();
      repeat (10) cycle(4'b1111, RR_DATA, 1'b1);

      // Holding 8'h11 from requester 1: backpressure, then release.
      repeat (5) cycle(4'b1111, RR_DATA, 1'b0);
      cycle(4'b1111, RR_DATA, 1'b1);
      cycle(4'b0010, RR_DATA, 1'b1);
      // last grant is 1: only requester 0 valid, grant wraps.
      cycle(4'b0001, RR_DATA, 1'b1);

      // Drain to EMPTY; data holds.
      repeat (2) cycle('0, RR_DATA, 1'b1);

      // Random traffic with random backpressure.
      for (int i = 0; i < 200; i++) begin
         cycle(N'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      end
      repeat (2) cycle('0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
